unary_op_scheduler: RTL

Round-robin scheduler that time-shares one serial unary operator (e.g. the unary multiply-by-two unit) among NUM_REQ requesters. It grants one requester at a time and clears the shared unit with a one-cycle local reset before each job. It then streams the granted requester's INPUT_WIDTH input bits into the unit and routes the unit's INPUT_WIDTH output bits back to that requester. It sits between the requester-side unary pipelines and a single shared operator instance.

---
 rtl/unary_op_scheduler.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/unary_op_scheduler.sv
// Round-robin time-sharing of one serial unary operator among NUM_REQ requesters.
// Define UNARY_SCHED_WATCHDOG_EN to abort stalled jobs after TIMEOUT idle cycles.
module unary_op_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int INPUT_WIDTH = 32,
  parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1),
  parameter int TIMEOUT     = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_bit,
  output logic [NUM_REQ-1:0] in_take,
  output logic [NUM_REQ-1:0] resp_valid,
  output logic               resp_bit,
  output logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] err,
  output logic               busy,
  output logic               unit_a,
  output logic               unit_ready,
  output logic               unit_rst_n,
  input  logic               unit_valid,
  input  logic               unit_y
);

  localparam int GW = $clog2(NUM_REQ);
  localparam logic [COUNT_WIDTH-1:0] WMAX =
    COUNT_WIDTH'(INPUT_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] WLAST =
    COUNT_WIDTH'(INPUT_WIDTH - 1);
  localparam logic [GW-1:0] LAST0 = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } state_t;

  state_t                 state_q;
  logic [GW-1:0]          grant_q;
  logic [GW-1:0]          last_q;
  logic [GW-1:0]          pick;
  logic [COUNT_WIDTH-1:0] in_cnt_q;
  logic [COUNT_WIDTH-1:0] out_cnt_q;
  logic                   unit_rst_n_q;
  logic                   busy_q;
  logic                   abort_q;
  logic                   found;
  int                     idx;
  logic                   feed;
  logic                   beat;
  logic                   last_beat;
  logic                   stall_hit;

  // First asserted request strictly after the previous winner.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!found && req[GW'(idx)]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  assign feed      = (state_q == RUN) && (in_cnt_q < WMAX);
  assign beat      = (state_q == RUN) && unit_valid;
  assign last_beat = beat && (out_cnt_q == WLAST);

`ifdef UNARY_SCHED_WATCHDOG_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_q;

  assign stall_hit = (state_q == RUN) && !unit_valid &&
                     (stall_q == SW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (state_q != RUN || unit_valid) begin
      stall_q <= '0;
    end else if (!stall_hit) begin
      stall_q <= stall_q + 1'b1;
    end
  end
`else
  assign stall_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_q       <= LAST0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      unit_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      unit_rst_n_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            state_q      <= CLEAR;
            grant_q      <= pick;
            unit_rst_n_q <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        CLEAR: begin
          in_cnt_q  <= '0;
          out_cnt_q <= '0;
          abort_q   <= 1'b0;
          state_q   <= RUN;
        end
        RUN: begin
          if (feed) in_cnt_q <= in_cnt_q + 1'b1;
          if (beat) out_cnt_q <= out_cnt_q + 1'b1;
          if (last_beat) begin
            state_q <= DONE;
          end else if (stall_hit) begin
            state_q <= DONE;
            abort_q <= 1'b1;
          end
        end
        DONE: begin
          last_q  <= grant_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    in_take    = '0;
    resp_valid = '0;
    done       = '0;
    err        = '0;
    unit_a     = 1'b0;
    unit_ready = 1'b0;
    resp_bit   = 1'b0;
    if (feed) begin
      in_take[grant_q] = 1'b1;
      unit_ready       = 1'b1;
      unit_a           = req_bit[grant_q];
    end
    if (state_q == RUN) begin
      resp_valid[grant_q] = unit_valid;
      resp_bit            = unit_y;
    end
    if (state_q == DONE) begin
      done[grant_q] = !abort_q;
      err[grant_q]  = abort_q;
    end
  end

  assign busy       = busy_q;
  assign unit_rst_n = unit_rst_n_q;

endmodule
